// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock-enable divider.
package clk_div_pkg;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  // Channel-select width, never narrower than one bit (n is at most 16).
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // A programmed limit of zero behaves as a limit of one (tick every cycle).
  function automatic logic [31:0] sanitize_limit(input logic [31:0] lim);
    return (lim == 32'd0) ? 32'd1 : lim;
  endfunction

endpackage

// File: rtl/clk_divider_multi_if.sv
// Limit-load port of the divider: master drives the request, slave answers ready.
// A transfer happens on the rising clk edge where load_valid && load_ready are both 1.
// load_ready is a combinational function of load_ch, so a master may retarget freely.
interface clk_divider_multi_if #(
  parameter int CNT_W = 26,
  parameter int CH_W  = 2
);
  logic             load_valid;
  logic [CH_W-1:0]  load_ch;
  logic [CNT_W-1:0] load_limit;
  logic             load_ready;

  modport master (output load_valid, output load_ch, output load_limit, input  load_ready);
  modport slave  (input  load_valid, input  load_ch, input  load_limit, output load_ready);
endinterface

// File: rtl/clk_div_channel.sv
// One divider channel: counter, live and shadow limit, toggle and tick registers.
// A written limit waits in the shadow until a wrap, a sync or a disabled cycle.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int               CNT_W         = 26,
  parameter logic [CNT_W-1:0] DEFAULT_LIMIT = CNT_W'(25000000)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             sync,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_data,
  output logic             pending,
  output logic             tick,
  output logic             div_out
);

  logic [CNT_W-1:0] cnt, limit, shadow;
  logic [CNT_W-1:0] lim_m1;
  logic [CNT_W-1:0] cnt_d;
  logic             toggle, toggle_d, tick_d, apply;

  assign lim_m1 = CNT_W'(sanitize_limit(32'(limit)) - 32'd1);

  // >= rather than == so a smaller limit applied while idle still wraps at once.
  always_comb begin
    cnt_d    = cnt;
    toggle_d = toggle;
    tick_d   = 1'b0;
    apply    = 1'b0;
    if (sync) begin
      cnt_d    = '0;
      toggle_d = 1'b0;
      apply    = pending;
    end else if (en) begin
      if (cnt >= lim_m1) begin
        cnt_d    = '0;
        tick_d   = 1'b1;
        toggle_d = ~toggle;
        apply    = pending;
      end else begin
        cnt_d = cnt + CNT_W'(1);
      end
    end else begin
      apply = pending;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      limit   <= DEFAULT_LIMIT;
      shadow  <= DEFAULT_LIMIT;
      pending <= 1'b0;
      toggle  <= 1'b0;
      tick    <= 1'b0;
      div_out <= 1'b0;
    end else begin
      cnt     <= cnt_d;
      toggle  <= toggle_d;
      tick    <= tick_d;
      div_out <= (mode == MODE_PULSE) ? tick_d : toggle_d;
      if (apply) begin
        limit   <= shadow;
        pending <= 1'b0;
      end
      // Never coincides with apply: the top only strobes a channel that is not pending.
      if (wr_en) begin
        shadow  <= wr_data;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_divider_multi.sv
// NUM_CH independent clock-enable generators from one system clock, with a
// per-channel retune port that takes effect only on a period boundary.
module clk_divider_multi
  import clk_div_pkg::*;
#(
  parameter int               NUM_CH        = 4,
  parameter int               CNT_W         = 26,
  parameter logic [CNT_W-1:0] DEFAULT_LIMIT = CNT_W'(25000000),
  localparam int              CH_W          = clog2_min1(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic [NUM_CH-1:0] mode,
  input  logic              sync,
  clk_divider_multi_if.slave load,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] div_out
);

  localparam int PAD_W = 1 << CH_W;

  logic [NUM_CH-1:0] pending, wr_en;
  logic [PAD_W-1:0]  pending_pad;
  logic              accept;

  // Unused select codes read a zero pad bit, so out-of-range loads are always ready.
  assign pending_pad     = PAD_W'(pending);
  assign load.load_ready = ~pending_pad[load.load_ch];
  assign accept          = load.load_valid & load.load_ready;

  always_comb begin
    wr_en = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_en[i] = accept && (load.load_ch == CH_W'(i));
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_channel #(
      .CNT_W         (CNT_W),
      .DEFAULT_LIMIT (DEFAULT_LIMIT)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en[i]),
      .mode    (mode[i]),
      .sync    (sync),
      .wr_en   (wr_en[i]),
      .wr_data (load.load_limit),
      .pending (pending[i]),
      .tick    (tick[i]),
      .div_out (div_out[i])
    );
  end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Bench for clk_divider_multi: directed scenarios plus random traffic, all
// checked every cycle against a behavioural model of the channel rules.
module tb_clk_divider_multi;
  import clk_div_pkg::*;

  localparam int NUM_CH = 5;
  localparam int CNT_W  = 8;
  localparam int DEF    = 5;
  localparam int CH_W   = clog2_min1(NUM_CH);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst, sync;
  logic [NUM_CH-1:0] en, mode, tick, div_out;

  initial forever #5 clk = ~clk;

  clk_divider_multi_if #(.CNT_W(CNT_W), .CH_W(CH_W)) lif ();

  clk_divider_multi #(
    .NUM_CH        (NUM_CH),
    .CNT_W         (CNT_W),
    .DEFAULT_LIMIT (CNT_W'(DEF))
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
    .sync    (sync),
    .load    (lif),
    .tick    (tick),
    .div_out (div_out)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int m_cnt [NUM_CH];
  int m_lim [NUM_CH];
  int m_sh  [NUM_CH];
  bit m_pend[NUM_CH];
  bit m_tog [NUM_CH];
  bit m_tick[NUM_CH];
  bit m_div [NUM_CH];
  bit m_valid = 1'b0;

  function automatic logic exp_ready(input logic [CH_W-1:0] ch);
    if (int'(ch) >= NUM_CH) return 1'b1;
    return !m_pend[int'(ch)];
  endfunction

  always @(posedge clk) begin
    bit acc;
    int lc;
    lc  = int'(lif.load_ch);
    acc = lif.load_valid && exp_ready(lif.load_ch);
    if (rst) begin
      m_valid = 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        m_cnt[c] = 0; m_lim[c] = DEF; m_sh[c] = DEF; m_pend[c] = 0;
        m_tog[c] = 0; m_tick[c] = 0; m_div[c] = 0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        int  period;
        bit  boundary;
        period   = (m_lim[c] == 0) ? 1 : m_lim[c];
        boundary = 1'b0;
        if (sync) begin
          m_cnt[c] = 0; m_tog[c] = 0; m_tick[c] = 0; boundary = 1'b1;
        end else if (!en[c]) begin
          m_tick[c] = 0; boundary = 1'b1;
        end else if (m_cnt[c] >= period - 1) begin
          m_cnt[c] = 0; m_tick[c] = 1; m_tog[c] = !m_tog[c]; boundary = 1'b1;
        end else begin
          m_cnt[c] = m_cnt[c] + 1; m_tick[c] = 0;
        end
        if (boundary && m_pend[c]) begin
          m_lim[c] = m_sh[c]; m_pend[c] = 0;
        end
        m_div[c] = mode[c] ? m_tick[c] : m_tog[c];
      end
      if (acc && lc < NUM_CH) begin
        m_sh[lc]   = int'(lif.load_limit);
        m_pend[lc] = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [NUM_CH-1:0] et, ed;
    if (m_valid) begin
      for (int c = 0; c < NUM_CH; c++) begin
        et[c] = m_tick[c];
        ed[c] = m_div[c];
      end
      check("tick", 32'(tick), 32'(et));
      check("div_out", 32'(div_out), 32'(ed));
      check("load_ready", 32'(lif.load_ready), 32'(exp_ready(lif.load_ch)));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_load(input int ch, input int val);
    lif.load_valid = 1'b1;
    lif.load_ch    = CH_W'(ch);
    lif.load_limit = CNT_W'(val);
    cyc(1);
    lif.load_valid = 1'b0;
  endtask

  task automatic wait_cnt(input int ch, input int val);
    int i;
    i = 0;
    while (m_cnt[ch] != val && i < 40) begin
      cyc(1);
      i++;
    end
    check("wait_cnt_reached", 32'(m_cnt[ch] == val), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    rst = 1'b1; sync = 1'b0; en = '1; mode = '0;
    lif.load_valid = 1'b0; lif.load_ch = '0; lif.load_limit = '0;
    cyc(3);
    check("reset_tick", 32'(tick), 32'd0);
    check("reset_div", 32'(div_out), 32'd0);
    check("reset_ready", 32'(lif.load_ready), 32'd1);

    // Default limit 5 in toggle mode: ticks at 5, 10, 15; div high 5..9.
    rst = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      cyc(1);
      if (k == 4)  check("lit_tick_k4", 32'(tick[0]), 32'd0);
      if (k == 5)  check("lit_tick_k5", 32'(tick[0]), 32'd1);
      if (k == 10) check("lit_tick_k10", 32'(tick[0]), 32'd1);
      if (k == 4)  check("lit_div_k4", 32'(div_out[0]), 32'd0);
      if (k == 5)  check("lit_div_k5", 32'(div_out[0]), 32'd1);
      if (k == 9)  check("lit_div_k9", 32'(div_out[0]), 32'd1);
      if (k == 10) check("lit_div_k10", 32'(div_out[0]), 32'd0);
      if (k == 15) check("lit_div_k15", 32'(div_out[0]), 32'd1);
    end

    // Limit 0 on ch1 ticks every cycle; limit 3 pulse mode on ch2.
    mode[2] = 1'b1;
    do_load(1, 0);
    do_load(2, 3);
    cyc(12);
    check("lit_ch1_tick_a", 32'(tick[1]), 32'd1);
    cyc(1);
    check("lit_ch1_tick_b", 32'(tick[1]), 32'd1);
    acc = 0;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      acc += int'(div_out[2]);
    end
    check("lit_ch2_pulses_per_3", 32'(acc), 32'd1);

    // Retune ch0 to 8 at cnt=2; a second load while pending is refused.
    wait_cnt(0, 2);
    lif.load_valid = 1'b1; lif.load_ch = '0; lif.load_limit = CNT_W'(8);
    cyc(1);
    lif.load_limit = CNT_W'(99);
    #1;
    check("lit_ready_pending", 32'(lif.load_ready), 32'd0);
    cyc(1);
    lif.load_valid = 1'b0;
    check("lit_ch0_no_tick_cnt4", 32'(tick[0]), 32'd0);
    cyc(1);
    check("lit_ch0_old_period_tick", 32'(tick[0]), 32'd1);
    cyc(7);
    check("lit_ch0_new_gap7", 32'(tick[0]), 32'd0);
    cyc(1);
    check("lit_ch0_new_gap8", 32'(tick[0]), 32'd1);

    // Pause ch3 at cnt=2 for 7 cycles; it resumes without phase loss.
    wait_cnt(3, 2);
    en[3] = 1'b0;
    for (int k = 0; k < 7; k++) begin
      cyc(1);
      check("lit_ch3_paused", 32'(tick[3]), 32'd0);
    end
    en[3] = 1'b1;
    cyc(2);
    check("lit_ch3_resume2", 32'(tick[3]), 32'd0);
    cyc(1);
    check("lit_ch3_resume3", 32'(tick[3]), 32'd1);

    // Sync pulse: everything clears, equal-limit channels align.
    cyc(2);
    sync = 1'b1;
    cyc(1);
    sync = 1'b0;
    check("lit_sync_div", 32'(div_out), 32'd0);
    check("lit_sync_tick", 32'(tick), 32'd0);
    cyc(4);
    check("lit_sync_ch34_k4", 32'(tick[4:3]), 32'd0);
    cyc(1);
    check("lit_sync_ch34_k5", 32'(tick[4:3]), 32'b11);

    // Reset mid-period with a pending load and a load offered during reset.
    cyc(2);
    do_load(4, 7);
    rst = 1'b1;
    lif.load_valid = 1'b1; lif.load_ch = CH_W'(3); lif.load_limit = CNT_W'(9);
    cyc(1);
    check("lit_rst_tick", 32'(tick), 32'd0);
    check("lit_rst_div", 32'(div_out), 32'd0);
    check("lit_rst_ready", 32'(lif.load_ready), 32'd1);
    rst = 1'b0; lif.load_valid = 1'b0;
    cyc(4);
    check("lit_post_rst_k4", 32'(tick[4:3]), 32'd0);
    cyc(1);
    check("lit_post_rst_k5", 32'(tick[4:3]), 32'b11);

    // Random traffic, checked by the model every cycle.
    for (int k = 0; k < 600; k++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        en[c] = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 15) == 0) mode[c] = ~mode[c];
      end
      sync           = ($urandom_range(0, 39) == 0);
      rst            = ($urandom_range(0, 149) == 0);
      lif.load_valid = ($urandom_range(0, 3) == 0);
      lif.load_ch    = CH_W'($urandom_range(0, (1 << CH_W) - 1));
      lif.load_limit = CNT_W'($urandom_range(0, 12));
      cyc(1);
    end
    rst = 1'b0; sync = 1'b0; lif.load_valid = 1'b0;
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
